// File: rtl/fetch_pc_stage.sv
// fetch_pc_stage: program counter and IF/ID pipeline register of the MIPS pipeline.
//   Advances the PC while the control unit enables fetching, drives the
//   instruction-memory address, and registers the fetched word with its PC+4.
//   Handles load-use stalls and branch/jump redirects (redirects flush IF/ID).
//
// Ports:
//   clk, reset      rising-edge clock, synchronous active-high reset
//   start_pc        fetch enable from control unit (HALT <-> RUN)
//   stall           hold PC and IF/ID
//   branch_taken    redirect to branch_target (highest priority)
//   branch_target   branch destination byte address ([1:0] ignored)
//   jump            redirect to jump_target
//   jump_target     jump destination byte address ([1:0] ignored)
//   imem_rdata      instruction word at imem_addr (combinational read)
//   imem_addr       current PC
//   if_id_instr     registered instruction (0 = NOP on bubble)
//   if_id_pc4       registered PC+4 of that instruction
//   if_id_valid     IF/ID holds a real instruction
//   fetch_count     instructions loaded valid into IF/ID (PERF_CNT_EN)
//   stall_count     RUN cycles stalled without redirect (PERF_CNT_EN)
//
// Build option: define PERF_CNT_EN to build the performance counters;
//   otherwise fetch_count and stall_count are tied to zero.

module fetch_pc_stage #(
  parameter int unsigned           DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = 32'h0040_0000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start_pc,
  input  logic                  stall,
  input  logic                  branch_taken,
  input  logic [DATA_WIDTH-1:0] branch_target,
  input  logic                  jump,
  input  logic [DATA_WIDTH-1:0] jump_target,
  input  logic [DATA_WIDTH-1:0] imem_rdata,
  output logic [DATA_WIDTH-1:0] imem_addr,
  output logic [DATA_WIDTH-1:0] if_id_instr,
  output logic [DATA_WIDTH-1:0] if_id_pc4,
  output logic                  if_id_valid,
  output logic [31:0]           fetch_count,
  output logic [31:0]           stall_count
);

  typedef enum logic {
    HALT = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t                r_state;
  logic [DATA_WIDTH-1:0] r_pc;
  logic [DATA_WIDTH-1:0] r_instr;
  logic [DATA_WIDTH-1:0] r_pc4;
  logic                  r_valid;

  logic [DATA_WIDTH-1:0] w_pc_plus4;
  logic [DATA_WIDTH-1:0] w_branch_tgt;
  logic [DATA_WIDTH-1:0] w_jump_tgt;
  logic                  w_redirect;
  logic                  w_load_valid;
  logic                  w_stall_cycle;

  always_comb begin
    w_pc_plus4    = r_pc + DATA_WIDTH'(4);
    w_branch_tgt  = {branch_target[DATA_WIDTH-1:2], 2'b00};
    w_jump_tgt    = {jump_target[DATA_WIDTH-1:2], 2'b00};
    w_redirect    = branch_taken | jump;
    w_load_valid  = (r_state == RUN) & ~w_redirect & ~stall;
    w_stall_cycle = (r_state == RUN) & ~w_redirect & stall;
  end

  // The cycle's action follows the current state; start_pc only selects the
  // state for the following cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= HALT;
      r_pc    <= RESET_PC;
      r_instr <= '0;
      r_pc4   <= '0;
      r_valid <= 1'b0;
    end else begin
      case (r_state)
        HALT: begin
          if (start_pc) r_state <= RUN;
          r_instr <= '0;
          r_valid <= 1'b0;
        end
        RUN: begin
          if (!start_pc) r_state <= HALT;
          if (branch_taken) begin
            r_pc    <= w_branch_tgt;
            r_instr <= '0;
            r_valid <= 1'b0;
          end else if (jump) begin
            r_pc    <= w_jump_tgt;
            r_instr <= '0;
            r_valid <= 1'b0;
          end else if (!stall) begin
            r_pc    <= w_pc_plus4;
            r_instr <= imem_rdata;
            r_pc4   <= w_pc_plus4;
            r_valid <= 1'b1;
          end
        end
        default: r_state <= HALT;
      endcase
    end
  end

`ifdef PERF_CNT_EN
  logic [31:0] r_fetch_cnt;
  logic [31:0] r_stall_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_fetch_cnt <= '0;
      r_stall_cnt <= '0;
    end else begin
      if (w_load_valid)  r_fetch_cnt <= r_fetch_cnt + 32'd1;
      if (w_stall_cycle) r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign fetch_count = r_fetch_cnt;
  assign stall_count = r_stall_cnt;
`else
  logic w_unused_perf;
  assign w_unused_perf = w_load_valid ^ w_stall_cycle;
  assign fetch_count   = '0;
  assign stall_count   = '0;
`endif

  assign imem_addr   = r_pc;
  assign if_id_instr = r_instr;
  assign if_id_pc4   = r_pc4;
  assign if_id_valid = r_valid;

endmodule
